// File: rtl/cpu_flag_unit.sv
// cpu_flag_unit: architectural flags register with forwarded branch resolution and a flags save stack
module cpu_flag_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       alu_valid,
  input  logic       OF_in,
  input  logic       CF_in,
  input  logic       ZF_in,
  input  logic       NF_in,
  input  logic       OF_en,
  input  logic       CF_en,
  input  logic       ZF_en,
  input  logic       NF_en,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  input  logic       flags_push,
  input  logic       flags_pop,
  output logic [3:0] flags_out,
  output logic       taken_valid,
  output logic       cond_taken,
  output logic       cond_err,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);
  localparam int PW = $clog2(STACK_DEPTH) + 1;
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [3:0] flags_q, flags_d, fwd, en, upd;
  logic [3:0] stack_q [STACK_DEPTH];
  logic [3:0] stack_d [STACK_DEPTH];
  logic [PW-1:0] top_q, top_d, top_m1;
  logic taken_valid_q, taken_valid_d, cond_taken_q, cond_taken_d;
  logic cond_err_q, cond_err_d, stack_err_q, stack_err_d;
  logic push_ok, pop_ok, lt;
  logic [15:0] cv;
  assign en = {OF_en, CF_en, ZF_en, NF_en} & {4{alu_valid}};
  assign upd = {OF_in, CF_in, ZF_in, NF_in};
  assign fwd = (flags_q & ~en) | (upd & en);
  assign top_m1 = top_q - PW'(1);
  assign stack_full = top_q == PW'(STACK_DEPTH);
  assign stack_empty = top_q == '0;
  assign flags_out = flags_q;
  assign taken_valid = taken_valid_q;
  assign cond_taken = cond_taken_q;
  assign cond_err = cond_err_q;
  assign stack_err = stack_err_q;
  always_comb begin
    push_ok = !stall & flags_push & !flags_pop & !stack_full;
    pop_ok = !stall & flags_pop & !flags_push & !stack_empty;
    lt = fwd[0] ^ fwd[3];
    // one bit per condition code, indexed directly by cond; C..E read as not-taken
    cv = {1'b1, 3'b000, fwd[1] | lt, !fwd[1] & !lt, !fwd[3], fwd[3],
          !fwd[0], fwd[0], !fwd[2], fwd[2], !lt, lt, !fwd[1], fwd[1]};
    stack_d = stack_q;
    if (push_ok) stack_d[top_q[IW-1:0]] = flags_q;
    top_d = push_ok ? top_q + PW'(1) : pop_ok ? top_m1 : top_q;
    flags_d = stall ? flags_q : pop_ok ? stack_q[top_m1[IW-1:0]] : fwd;
    taken_valid_d = cond_valid & !stall;
    cond_taken_d = taken_valid_d ? cv[cond] : cond_taken_q;
    cond_err_d = taken_valid_d ? (cond >= 4'hC && cond <= 4'hE) : cond_err_q;
    stack_err_d = !stall & ((flags_push & flags_pop) | (flags_push & stack_full) |
                            (flags_pop & stack_empty));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      stack_q <= '{default: '0};
      top_q <= '0;
      taken_valid_q <= 1'b0;
      cond_taken_q <= 1'b0;
      cond_err_q <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      stack_q <= stack_d;
      top_q <= top_d;
      taken_valid_q <= taken_valid_d;
      cond_taken_q <= cond_taken_d;
      cond_err_q <= cond_err_d;
      stack_err_q <= stack_err_d;
    end
  end
endmodule

// File: tb/tb_cpu_flag_unit.sv
// tb_cpu_flag_unit: directed vectors checked against a behavioural flags/stack model every cycle
module tb_cpu_flag_unit;
  logic clk = 0, rst, stall, alu_valid;
  logic OF_in, CF_in, ZF_in, NF_in, OF_en, CF_en, ZF_en, NF_en;
  logic cond_valid, flags_push, flags_pop;
  logic [3:0] cond, flags_out;
  logic taken_valid, cond_taken, cond_err, stack_full, stack_empty, stack_err;
  int n_chk = 0, n_fail = 0;
  bit started = 0;
  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  logic m_tv, m_ct, m_ce, m_se;

  cpu_flag_unit #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_valid(alu_valid),
    .OF_in(OF_in), .CF_in(CF_in), .ZF_in(ZF_in), .NF_in(NF_in),
    .OF_en(OF_en), .CF_en(CF_en), .ZF_en(ZF_en), .NF_en(NF_en),
    .cond_valid(cond_valid), .cond(cond), .flags_push(flags_push), .flags_pop(flags_pop),
    .flags_out(flags_out), .taken_valid(taken_valid), .cond_taken(cond_taken),
    .cond_err(cond_err), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // {taken, err} from the architectural condition table
  function automatic logic [1:0] eval(input logic [3:0] f, input logic [3:0] c);
    logic o, cf, z, n;
    {o, cf, z, n} = f;
    case (c)
      4'h0: return {z, 1'b0};
      4'h1: return {!z, 1'b0};
      4'h2: return {n != o, 1'b0};
      4'h3: return {n == o, 1'b0};
      4'h4: return {cf, 1'b0};
      4'h5: return {!cf, 1'b0};
      4'h6: return {n, 1'b0};
      4'h7: return {!n, 1'b0};
      4'h8: return {o, 1'b0};
      4'h9: return {!o, 1'b0};
      4'hA: return {!z && n == o, 1'b0};
      4'hB: return {z || n != o, 1'b0};
      4'hF: return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] f, ins, ens;
    if (rst) begin
      m_flags = 0; m_stk = {}; m_tv = 0; m_ct = 0; m_ce = 0; m_se = 0;
    end else if (stall) begin
      m_tv = 0; m_se = 0;
    end else begin
      ins = {OF_in, CF_in, ZF_in, NF_in};
      ens = alu_valid ? {OF_en, CF_en, ZF_en, NF_en} : 4'b0;
      f = m_flags;
      for (int i = 0; i < 4; i++) if (ens[i]) f[i] = ins[i];
      m_tv = cond_valid;
      if (cond_valid) {m_ct, m_ce} = eval(f, cond);
      m_se = 0;
      if (flags_push && flags_pop) m_se = 1;
      else if (flags_push && m_stk.size() == 4) m_se = 1;
      else if (flags_pop && m_stk.size() == 0) m_se = 1;
      if (flags_push && !flags_pop && m_stk.size() < 4) m_stk.push_back(m_flags);
      if (flags_pop && !flags_push && m_stk.size() > 0) f = m_stk.pop_back();
      m_flags = f;
    end
    started = 1;
  end

  always @(negedge clk) if (started) begin
    chk("flags_out", flags_out, m_flags);
    chk("taken_valid", {3'b0, taken_valid}, {3'b0, m_tv});
    chk("cond_taken", {3'b0, cond_taken}, {3'b0, m_ct});
    chk("cond_err", {3'b0, cond_err}, {3'b0, m_ce});
    chk("stack_full", {3'b0, stack_full}, {3'b0, m_stk.size() == 4});
    chk("stack_empty", {3'b0, stack_empty}, {3'b0, m_stk.size() == 0});
    chk("stack_err", {3'b0, stack_err}, {3'b0, m_se});
  end

  task automatic idle();
    rst = 0; stall = 0; alu_valid = 0; cond_valid = 0; cond = 0;
    flags_push = 0; flags_pop = 0;
    {OF_in, CF_in, ZF_in, NF_in} = 0; {OF_en, CF_en, ZF_en, NF_en} = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic alu(input logic [3:0] v, input logic [3:0] e);
    alu_valid = 1; {OF_in, CF_in, ZF_in, NF_in} = v; {OF_en, CF_en, ZF_en, NF_en} = e;
  endtask

  task automatic evalc(input logic [3:0] c, input logic t, input logic e, input string nm);
    cond_valid = 1; cond = c; cyc();
    chk({nm, "_valid"}, {3'b0, taken_valid}, 4'h1);
    chk({nm, "_taken"}, {3'b0, cond_taken}, {3'b0, t});
    chk({nm, "_err"}, {3'b0, cond_err}, {3'b0, e});
  endtask

  initial begin
    logic [3:0] pv[4];
    pv = '{4'b0011, 4'b0111, 4'b1111, 4'b1000};
    idle(); rst = 1;
    cyc(); rst = 1; cyc();
    cyc();
    chk("rst_flags", flags_out, 4'b0000);
    chk("rst_empty", {3'b0, stack_empty}, 4'h1);
    chk("rst_tv", {3'b0, taken_valid}, 4'h0);
    // ZF forwarded into same-cycle EQ evaluation
    alu(4'b0010, 4'b0010); cond_valid = 1; cond = 4'h0; cyc();
    chk("fwd_eq_valid", {3'b0, taken_valid}, 4'h1);
    chk("fwd_eq_taken", {3'b0, cond_taken}, 4'h1);
    chk("fwd_eq_flags", flags_out, 4'b0010);
    cyc();
    chk("tv_pulse", {3'b0, taken_valid}, 4'h0);
    alu(4'b0001, 4'b1111); cyc();
    chk("nf_flags", flags_out, 4'b0001);
    evalc(4'h2, 1, 0, "lt");
    evalc(4'hA, 0, 0, "gt");
    evalc(4'hC, 0, 1, "rsvd");
    evalc(4'hB, 1, 0, "le");
    evalc(4'hF, 1, 0, "al");
    evalc(4'h4, 0, 0, "ltu");
    // push stores pre-update flags while the ALU update still lands
    for (int i = 0; i < 4; i++) begin
      flags_push = 1; alu(pv[i], 4'b1111); cyc();
    end
    chk("full", {3'b0, stack_full}, 4'h1);
    chk("full_flags", flags_out, 4'b1000);
    flags_push = 1; cyc();
    chk("push_full_err", {3'b0, stack_err}, 4'h1);
    cyc();
    chk("err_pulse", {3'b0, stack_err}, 4'h0);
    flags_pop = 1; alu(4'b0000, 4'b0100); cyc();
    chk("pop_over_alu", flags_out, 4'b1111);
    flags_pop = 1; cyc(); chk("pop2", flags_out, 4'b0111);
    flags_pop = 1; cyc(); chk("pop3", flags_out, 4'b0011);
    flags_pop = 1; cyc(); chk("pop4", flags_out, 4'b0001);
    chk("pop_empty", {3'b0, stack_empty}, 4'h1);
    flags_pop = 1; cyc();
    chk("pop_empty_err", {3'b0, stack_err}, 4'h1);
    chk("pop_empty_flags", flags_out, 4'b0001);
    flags_push = 1; flags_pop = 1; alu(4'b0100, 4'b0100); cyc();
    chk("pushpop_err", {3'b0, stack_err}, 4'h1);
    chk("pushpop_alu", flags_out, 4'b0101);
    chk("pushpop_empty", {3'b0, stack_empty}, 4'h1);
    stall = 1; alu(4'b1010, 4'b1111); flags_push = 1; cond_valid = 1; cond = 4'hF; cyc();
    chk("stall_flags", flags_out, 4'b0101);
    chk("stall_tv", {3'b0, taken_valid}, 4'h0);
    chk("stall_empty", {3'b0, stack_empty}, 4'h1);
    flags_push = 1; cyc();
    flags_push = 1; cyc();
    chk("mid_notempty", {3'b0, stack_empty}, 4'h0);
    rst = 1; stall = 1; cond_valid = 1; cond = 4'hF; cyc();
    chk("mid_rst_empty", {3'b0, stack_empty}, 4'h1);
    chk("mid_rst_flags", flags_out, 4'b0000);
    chk("mid_rst_tv", {3'b0, taken_valid}, 4'h0);
    cyc(); cyc();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
